// File: rtl/ballot_pkg.sv
// ballot_pkg: shared FSM state, candidate type, mode encodings and button helper
package ballot_pkg;
  localparam int NUM_CANDIDATES = 4;
  localparam logic VOTE_MODE = 1'b0;
  localparam logic DISPLAY_MODE = 1'b1;
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, ISSUE, LOCK} state_t;
  typedef logic [1:0] cand_t;
  function automatic cand_t lowest_idx(input logic [NUM_CANDIDATES-1:0] b);
    return b[0] ? 2'd0 : b[1] ? 2'd1 : b[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/ballot_press_filter.sv
// ballot_press_filter: button edge detect, multi-press detect and hold counter
// ports: clk, reset; btn[3:0] raw buttons; hold_load/hold_inc counter controls;
//        rise/rise_idx edges, idx lowest pressed, single/multi, hold_reached
module ballot_press_filter
  import ballot_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       hold_load,
  input  logic       hold_inc,
  output logic [3:0] rise,
  output logic [1:0] rise_idx,
  output logic [1:0] idx,
  output logic       single,
  output logic       multi,
  output logic       hold_reached
);
  logic [3:0] prev;
  logic [7:0] hold_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      hold_cnt <= '0;
    end else begin
      prev <= btn;
      hold_cnt <= hold_load ? 8'd1 : hold_inc ? hold_cnt + 8'd1 : '0;
    end
  end
  always_comb begin
    rise = btn & ~prev;
    rise_idx = lowest_idx(rise);
    idx = lowest_idx(btn);
    multi = (btn & (btn - 4'd1)) != '0;
    single = |btn && !multi;
    // true when this cycle's increment lands on HOLD_CYCLES
    hold_reached = {1'b0, hold_cnt} + 9'd1 == 9'(HOLD_CYCLES);
  end
endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: ballot FSM issuing one counter increment per voter, plus led mux
// ports: clk, reset; mode, button1..4, voter_ready, inc_ready, count_data in;
//        inc_valid, inc_sel, count_sel, led, ballot_open, spoiled out
module ballot_controller
  import ballot_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int LOCK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  input  logic       voter_ready,
  output logic       inc_valid,
  output logic [1:0] inc_sel,
  input  logic       inc_ready,
  output logic [1:0] count_sel,
  input  logic [7:0] count_data,
  output logic [7:0] led,
  output logic       ballot_open,
  output logic       spoiled
);
  state_t state, nxt;
  cand_t cand;
  logic [3:0] btn, rise, mine, last_oh;
  logic [1:0] rise_idx, idx;
  logic [7:0] lock_cnt, disp_q;
  logic single, multi, hold_reached, block, extra, hold_load, hold_inc, disp, mode_q, lock_done;
  assign btn = {button4, button3, button2, button1};
  assign mine = 4'b1 << cand;
  assign extra = |(btn & ~mine);
  assign hold_load = state == ARMED && !block && single;
  assign hold_inc = state == CAPTURE && btn == mine;
  assign disp = state == IDLE && mode == DISPLAY_MODE;
  assign lock_done = btn == '0 && {1'b0, lock_cnt} + 9'd1 == 9'(LOCK_CYCLES);
  ballot_press_filter #(.HOLD_CYCLES(HOLD_CYCLES)) u_filter (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .hold_load(hold_load),
    .hold_inc(hold_inc),
    .rise(rise),
    .rise_idx(rise_idx),
    .idx(idx),
    .single(single),
    .multi(multi),
    .hold_reached(hold_reached)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = mode == VOTE_MODE && voter_ready ? ARMED : IDLE;
      ARMED:   nxt = hold_load ? (HOLD_CYCLES == 1 ? ISSUE : CAPTURE) : ARMED;
      CAPTURE: nxt = btn != mine ? ARMED : hold_reached ? ISSUE : CAPTURE;
      ISSUE:   nxt = inc_ready ? LOCK : ISSUE;
      LOCK:    nxt = lock_done ? IDLE : LOCK;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    inc_valid = state == ISSUE;
    inc_sel = cand;
    ballot_open = state == ARMED || state == CAPTURE;
    spoiled = (state == ARMED && !block && multi) || (state == CAPTURE && extra);
    led = mode_q ? disp_q : {ballot_open, 3'b000, last_oh};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= '0;
      block <= 1'b0;
      lock_cnt <= '0;
      last_oh <= '0;
      count_sel <= '0;
      mode_q <= 1'b0;
      disp_q <= '0;
    end else begin
      cand <= hold_load ? idx : cand;
      // after a spoiled press, buttons stay ignored until all are released
      block <= state == ARMED ? (block ? |btn : multi) : state == CAPTURE && extra;
      lock_cnt <= state == LOCK && btn == '0 ? lock_cnt + 8'd1 : '0;
      last_oh <= inc_valid && inc_ready ? mine : last_oh;
      count_sel <= disp && |rise ? rise_idx : count_sel;
      mode_q <= disp;
      disp_q <= count_data;
    end
  end
endmodule
